// File: rtl/compensation_accumulator_array.sv
// Multi-channel saturating tile accumulator with a valid/ready result register.
// The next tile keeps accumulating while a result waits; only its final beat is held off.
module compensation_accumulator_array #(
  parameter int CH    = 8,
  parameter int IN_W  = 14,
  parameter int ACC_W = 20,
  parameter int LEN_W = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  Cal,
  output logic                  in_ready,
  input  logic [CH*IN_W-1:0]    Compensation_Sum_in,
  input  logic [LEN_W-1:0]      cfg_len,
  input  logic                  clr,
  output logic [CH*ACC_W-1:0]   Compensation_Sum_out,
  output logic [CH-1:0]         sat_flag,
  output logic                  out_valid,
  input  logic                  out_ready
);

  logic signed [ACC_W-1:0] acc_q [CH];
  logic signed [ACC_W-1:0] acc_d [CH];
  logic signed [ACC_W:0]   ext   [CH];
  logic signed [ACC_W:0]   sum   [CH];
  logic [CH-1:0]           clip;
  logic [CH-1:0]           sat_q, sat_d;
  logic [CH-1:0]           flag_q, flag_d;
  logic [LEN_W-1:0]        cnt_q, cnt_d;
  logic [LEN_W-1:0]        len_q, len_d;
  logic [CH*ACC_W-1:0]     res_q, res_d;
  logic                    vld_q, vld_d;
  logic                    first, last_pending, accept;

  always_comb begin
    first        = (cnt_q == '0);
    // A first beat with cfg_len==0 is also the final beat, so it must see the live cfg_len.
    last_pending = first ? (cfg_len == '0) : (cnt_q == len_q);
    in_ready     = !(vld_q && last_pending);
    accept       = Cal && in_ready && !clr;

    for (int i = 0; i < CH; i++) begin
      ext[i]  = {{(ACC_W+1-IN_W){Compensation_Sum_in[i*IN_W+IN_W-1]}},
                 Compensation_Sum_in[i*IN_W +: IN_W]};
      sum[i]  = {acc_q[i][ACC_W-1], acc_q[i]} + ext[i];
      clip[i] = (sum[i][ACC_W] != sum[i][ACC_W-1]);
    end

    for (int i = 0; i < CH; i++) acc_d[i] = acc_q[i];
    sat_d  = sat_q;
    flag_d = flag_q;
    cnt_d  = cnt_q;
    len_d  = len_q;
    res_d  = res_q;
    vld_d  = vld_q;

    if (vld_q && out_ready) vld_d = 1'b0;

    if (clr) begin
      cnt_d = '0;
      sat_d = '0;
      for (int i = 0; i < CH; i++) acc_d[i] = '0;
    end else if (accept) begin
      for (int i = 0; i < CH; i++) begin
        if (first)
          acc_d[i] = ext[i][ACC_W-1:0];
        else if (clip[i])
          acc_d[i] = sum[i][ACC_W] ? {1'b1, {(ACC_W-1){1'b0}}} : {1'b0, {(ACC_W-1){1'b1}}};
        else
          acc_d[i] = sum[i][ACC_W-1:0];
      end
      sat_d = first ? '0 : (sat_q | clip);
      if (first) len_d = cfg_len;
      if (last_pending) begin
        cnt_d  = '0;
        vld_d  = 1'b1;
        flag_d = sat_d;
        for (int i = 0; i < CH; i++) res_d[i*ACC_W +: ACC_W] = acc_d[i];
      end else begin
        cnt_d = cnt_q + LEN_W'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < CH; i++) acc_q[i] <= '0;
      sat_q  <= '0;
      flag_q <= '0;
      cnt_q  <= '0;
      len_q  <= '0;
      res_q  <= '0;
      vld_q  <= 1'b0;
    end else begin
      for (int i = 0; i < CH; i++) acc_q[i] <= acc_d[i];
      sat_q  <= sat_d;
      flag_q <= flag_d;
      cnt_q  <= cnt_d;
      len_q  <= len_d;
      res_q  <= res_d;
      vld_q  <= vld_d;
    end
  end

  assign Compensation_Sum_out = res_q;
  assign sat_flag             = flag_q;
  assign out_valid            = vld_q;

endmodule

// File: tb/tb_compensation_accumulator_array.sv
// Randomised and directed bench for compensation_accumulator_array against a tile-level model.
module tb_compensation_accumulator_array;
  localparam int CH = 8, IN_W = 14, ACC_W = 20, LEN_W = 8;
  localparam longint AMAX = (longint'(1) << (ACC_W-1)) - 1;
  localparam longint AMIN = -(longint'(1) << (ACC_W-1));

  logic clk = 1'b0;
  logic rst, Cal, clr, out_ready, in_ready, out_valid;
  logic [LEN_W-1:0]    cfg_len;
  logic [CH*IN_W-1:0]  sum_in;
  logic [CH*ACC_W-1:0] sum_out;
  logic [CH-1:0]       sat_flag;

  int n_tests = 0;
  int n_fail  = 0;

  compensation_accumulator_array #(.CH(CH), .IN_W(IN_W), .ACC_W(ACC_W), .LEN_W(LEN_W)) dut (
    .clk(clk), .rst(rst), .Cal(Cal), .in_ready(in_ready),
    .Compensation_Sum_in(sum_in), .cfg_len(cfg_len), .clr(clr),
    .Compensation_Sum_out(sum_out), .sat_flag(sat_flag),
    .out_valid(out_valid), .out_ready(out_ready));

  initial forever #5 clk = ~clk;

  // Tile-level model: running sums as plain integers, clamped to the result range.
  int          lane_v [CH];
  int          m_cnt, m_len;
  longint      m_acc [CH];
  longint      m_res [CH];
  logic [CH-1:0] m_sat, m_flag;
  bit          m_vld;

  task automatic chk(input string name, input longint act, input longint exp);
    n_tests++;
    if (act != exp) begin
      n_fail++;
      if (n_fail <= 40) $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  function automatic longint lane_out(input int i);
    logic signed [ACC_W-1:0] t;
    t = sum_out[i*ACC_W +: ACC_W];
    return longint'(t);
  endfunction

  function automatic bit m_last();
    return (m_cnt == 0) ? (cfg_len == 0) : (m_cnt == m_len);
  endfunction

  function automatic bit m_ready();
    return !(m_vld && m_last());
  endfunction

  task automatic model_reset();
    m_cnt = 0; m_len = 0; m_vld = 0; m_sat = '0; m_flag = '0;
    for (int i = 0; i < CH; i++) begin m_acc[i] = 0; m_res[i] = 0; end
  endtask

  task automatic model_step();
    bit rdy, fin;
    longint s;
    if (!rst) begin
      model_reset();
      return;
    end
    rdy = m_ready();
    fin = m_last();
    if (m_vld && out_ready) m_vld = 0;
    if (clr) begin
      m_cnt = 0; m_sat = '0;
      for (int i = 0; i < CH; i++) m_acc[i] = 0;
    end else if (Cal && rdy) begin
      if (m_cnt == 0) begin
        m_len = int'(cfg_len);
        m_sat = '0;
        for (int i = 0; i < CH; i++) m_acc[i] = lane_v[i];
      end else begin
        for (int i = 0; i < CH; i++) begin
          s = m_acc[i] + lane_v[i];
          if (s > AMAX) begin s = AMAX; m_sat[i] = 1'b1; end
          else if (s < AMIN) begin s = AMIN; m_sat[i] = 1'b1; end
          m_acc[i] = s;
        end
      end
      if (fin) begin
        for (int i = 0; i < CH; i++) m_res[i] = m_acc[i];
        m_flag = m_sat;
        m_vld  = 1;
        m_cnt  = 0;
      end else begin
        m_cnt++;
      end
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    model_step();
    #2;
  endtask

  task automatic pack();
    for (int i = 0; i < CH; i++) sum_in[i*IN_W +: IN_W] = lane_v[i][IN_W-1:0];
  endtask

  task automatic setall(input int v);
    for (int i = 0; i < CH; i++) lane_v[i] = v;
    pack();
  endtask

  task automatic take();
    Cal = 0; out_ready = 1; cyc(); out_ready = 0;
  endtask

  // Compare process: every falling edge the DUT must match the model.
  initial begin
    forever begin
      @(negedge clk);
      chk("in_ready", in_ready, m_ready());
      chk("out_valid", out_valid, m_vld);
      chk("sat_flag", sat_flag, m_flag);
      for (int i = 0; i < CH; i++) chk($sformatf("lane%0d", i), lane_out(i), m_res[i]);
    end
  end

  initial begin
    int mode, r;
    rst = 0; Cal = 0; clr = 0; out_ready = 0; cfg_len = '0;
    model_reset();
    setall(0);
    repeat (3) cyc();
    rst = 1;
    chk("rst_in_ready", in_ready, 1);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_sum", sum_out, 0);
    chk("rst_sat", sat_flag, 0);

    // four beats 1..4
    cfg_len = 3; Cal = 1;
    for (int b = 1; b <= 4; b++) begin
      setall(b);
      if (b == 4) chk("t1_not_yet", out_valid, 0);
      cyc();
    end
    Cal = 0;
    chk("t1_valid", out_valid, 1);
    for (int i = 0; i < CH; i++) chk("t1_lane", lane_out(i), 10);
    chk("t1_sat", sat_flag, 0);
    take();

    // extremes without clamping
    Cal = 1;
    for (int b = 0; b < 4; b++) begin
      setall(8191); lane_v[0] = -8192; pack(); cyc();
    end
    Cal = 0;
    chk("t2_lane0", lane_out(0), -32768);
    chk("t2_lane5", lane_out(5), 32764);
    chk("t2_sat", sat_flag, 0);
    take();

    // 65 beats saturate lane 3
    cfg_len = 64; Cal = 1;
    setall(0); lane_v[3] = 8191; pack();
    repeat (65) cyc();
    Cal = 0;
    chk("t3_lane3", lane_out(3), 524287);
    chk("t3_lane0", lane_out(0), 0);
    chk("t3_sat", sat_flag, 8'h08);
    take();
    cfg_len = 0; Cal = 1; setall(1); cyc(); Cal = 0;
    chk("t3_next_sat", sat_flag, 0);
    chk("t3_next_lane", lane_out(3), 1);
    take();

    // overlap with stalled consumer
    cfg_len = 1; Cal = 1; setall(1);
    cyc(); cyc();
    chk("t4_first_valid", out_valid, 1);
    setall(2);
    chk("t4_overlap_ready", in_ready, 1);
    cyc();
    setall(3);
    chk("t4_final_blocked", in_ready, 0);
    cyc(); cyc();
    chk("t4_hold_lane", lane_out(2), 2);
    out_ready = 1; cyc(); out_ready = 0;
    chk("t4_taken", out_valid, 0);
    chk("t4_ready_again", in_ready, 1);
    cyc();
    Cal = 0;
    chk("t4_second_valid", out_valid, 1);
    chk("t4_second_lane", lane_out(7), 5);
    take();

    // clr aborts a partial tile
    cfg_len = 3; Cal = 1; setall(9);
    cyc(); cyc();
    clr = 1; setall(100); cyc(); clr = 0;
    setall(5);
    cyc(); cyc(); cyc();
    chk("t5_old_lane", lane_out(0), 5);
    chk("t5_not_valid", out_valid, 0);
    cyc(); Cal = 0;
    chk("t5_valid", out_valid, 1);
    chk("t5_lane", lane_out(4), 20);
    take();

    // single-beat tiles
    cfg_len = 0; Cal = 1; setall(7); cyc(); Cal = 0;
    chk("t6_first", lane_out(1), 7);
    take();
    Cal = 1; setall(-3); cyc(); Cal = 0;
    chk("t6_second", lane_out(1), -3);
    chk("t6_valid", out_valid, 1);

    // reset in the middle of a tile
    cfg_len = 3; Cal = 1; setall(4); cyc(); cyc(); Cal = 0;
    #1 rst = 0; model_reset();
    #1;
    chk("t7_valid_async", out_valid, 0);
    chk("t7_sum_async", sum_out, 0);
    chk("t7_sat_async", sat_flag, 0);
    cyc(); cyc();
    rst = 1;
    chk("t7_ready_after", in_ready, 1);

    // randomised traffic
    for (int c = 0; c < 3000; c++) begin
      if (c == 1700) begin
        #1 rst = 0; model_reset(); cyc(); rst = 1;
      end
      mode = (c / 500) % 3;
      Cal = ($urandom % 10) < 7;
      clr = ($urandom % 40) == 0;
      out_ready = $urandom % 2;
      r = $urandom % 20;
      cfg_len = (r == 0) ? LEN_W'($urandom_range(100, 255)) : LEN_W'($urandom % 6);
      for (int i = 0; i < CH; i++) begin
        r = $urandom % 10;
        if (mode == 1 && r < 8) lane_v[i] = 8191;
        else if (mode == 2 && r < 8) lane_v[i] = -8192;
        else lane_v[i] = int'($urandom_range(0, 16383)) - 8192;
      end
      pack();
      cyc();
    end
    Cal = 0; clr = 0; out_ready = 1;
    cyc(); cyc();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
